// File: rtl/time_set_pkg.sv
// Shared definitions for the keypad time-entry controller.
// Holds the FSM state encoding, keypad/cursor sentinels, per-position digit
// limits and the BCD field layout of the 24-bit HH:MM:SS time word.
package time_set_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_REL = 3'd1,
    ST_WAIT_KEY = 3'd2,
    ST_DEBOUNCE = 3'd3,
    ST_APPLY    = 3'd4,
    ST_COMMIT   = 3'd5,
    ST_LOCKOUT  = 3'd6
  } state_e;

  localparam logic [9:0] KEY_NONE  = 10'h3FF;
  localparam logic [2:0] EDIT_IDLE = 3'd7;
  localparam logic [2:0] POS_LAST  = 3'd5;

  // Largest digit accepted at each cursor position.
  localparam logic [3:0] LIM_H_TEN    = 4'd2;
  localparam logic [3:0] LIM_H_ONE    = 4'd9;
  localparam logic [3:0] LIM_H_ONE_20 = 4'd3;  // hours 20..23
  localparam logic [3:0] LIM_M_TEN    = 4'd5;
  localparam logic [3:0] LIM_M_ONE    = 4'd9;
  localparam logic [3:0] LIM_S_TEN    = 4'd5;
  localparam logic [3:0] LIM_S_ONE    = 4'd9;

  // LSB offsets of each BCD digit inside the time word.
  localparam logic [4:0] H_TEN_LSB = 5'd20;
  localparam logic [4:0] H_ONE_LSB = 5'd16;
  localparam logic [4:0] M_TEN_LSB = 5'd12;
  localparam logic [4:0] M_ONE_LSB = 5'd8;
  localparam logic [4:0] S_TEN_LSB = 5'd4;
  localparam logic [4:0] S_ONE_LSB = 5'd0;

  function automatic logic [4:0] field_lsb(input logic [2:0] pos);
    logic [4:0] lsb;
    case (pos)
      3'd0:    lsb = H_TEN_LSB;
      3'd1:    lsb = H_ONE_LSB;
      3'd2:    lsb = M_TEN_LSB;
      3'd3:    lsb = M_ONE_LSB;
      3'd4:    lsb = S_TEN_LSB;
      default: lsb = S_ONE_LSB;
    endcase
    return lsb;
  endfunction

  // The hour-units limit depends on the hour-tens digit already staged.
  function automatic logic [3:0] digit_limit(input logic [2:0] pos,
                                             input logic [3:0] h_ten);
    logic [3:0] lim;
    case (pos)
      3'd0:    lim = LIM_H_TEN;
      3'd1:    lim = (h_ten == 4'd2) ? LIM_H_ONE_20 : LIM_H_ONE;
      3'd2:    lim = LIM_M_TEN;
      3'd3:    lim = LIM_M_ONE;
      3'd4:    lim = LIM_S_TEN;
      default: lim = LIM_S_ONE;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad qualifier for the time-entry controller.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   keypad[9:0]     active-low one-hot keys
//   arm             controller is waiting for a new key
//   hold            controller is debouncing the latched key
//   key_start       a single key is present while armed; code latched this edge
//   key_valid       latched code stayed stable for DEBOUNCE cycles (one cycle)
//   key_lost        keypad changed while debouncing
//   key_digit[3:0]  digit of the latched code
module key_debounce
  import time_set_pkg::*;
#(
  parameter int DEBOUNCE = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keypad,
  input  logic       arm,
  input  logic       hold,
  output logic       key_start,
  output logic       key_valid,
  output logic       key_lost,
  output logic [3:0] key_digit
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [9:0]    code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    pressed;
  logic          one_hot;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign pressed = ~keypad;
  assign one_hot = (pressed != 10'd0) && ((pressed & (pressed - 10'd1)) == 10'd0);

  always_comb begin
    key_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (!code_q[i]) key_digit = 4'(i);
    end
  end

  // Down-counter loaded on latch; terminal count 0 qualifies the key.
  always_comb begin
    code_d    = code_q;
    cnt_d     = cnt_q;
    key_start = 1'b0;
    key_valid = 1'b0;
    key_lost  = 1'b0;
    if (arm && one_hot) begin
      key_start = 1'b1;
      code_d    = keypad;
      cnt_d     = CW'(DEBOUNCE - 1);
    end else if (hold) begin
      if (keypad != code_q) begin
        key_lost = 1'b1;
      end else if (cnt_q == '0) begin
        key_valid = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q <= KEY_NONE;
      cnt_q  <= '0;
    end else begin
      code_q <= code_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Keypad time-entry controller for the six BCD watch counters.
// Ports:
//   clk, rst         1 kHz system clock, asynchronous active-low reset
//   set_en           edit mode requested (DIP switch)
//   keypad[9:0]      active-low one-hot digit keys, 10'h3FF = none
//   cur_time[23:0]   live watch time, BCD HH:MM:SS
//   load_time[23:0]  validated time to load, qualified by load_stb
//   load_stb         one-cycle load pulse
//   edit_time[23:0]  staged buffer while editing, live time otherwise
//   edit_pos[2:0]    cursor 0..5 (h_ten..s_one), 7 when not editing
//   blink_mask[5:0]  1 = blank that digit this cycle (bit 5 = h_ten)
//   busy             high outside IDLE
//   err              one-cycle pulse on a rejected digit
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | not editing; snapshot cur_time when set_en rises
// WAIT_REL | wait for all keys released
// WAIT_KEY | wait for a single-key code
// DEBOUNCE | latched key must stay stable DEBOUNCE cycles
// APPLY    | range-check the digit and write it into the buffer
// COMMIT   | one-cycle load strobe of the buffer
// LOCKOUT  | edit abandoned on timeout; wait for set_en low
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DEBOUNCE   = 20,
  parameter int TIMEOUT    = 10000,
  parameter int BLINK_HALF = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_en,
  input  logic [9:0]  keypad,
  input  logic [23:0] cur_time,
  output logic [23:0] load_time,
  output logic        load_stb,
  output logic [23:0] edit_time,
  output logic [2:0]  edit_pos,
  output logic [5:0]  blink_mask,
  output logic        busy,
  output logic        err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  state_e        state_q, state_d;
  logic [23:0]   buf_q, buf_d;
  logic [2:0]    pos_q, pos_d;
  logic          dirty_q, dirty_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  logic [23:0]   load_time_q, load_time_d;
  logic          load_stb_q, load_stb_d;
  logic [23:0]   edit_time_q, edit_time_d;
  logic [2:0]    edit_pos_q, edit_pos_d;
  logic [5:0]    blink_mask_q, blink_mask_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic          key_start, key_valid, key_lost;
  logic [3:0]    key_digit;
  logic          waiting, timed_out, reject, edit_view;
  logic [3:0]    lim;
  logic [4:0]    lsb;

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key_debounce (
    .clk       (clk),
    .rst       (rst),
    .keypad    (keypad),
    .arm       (state_q == ST_WAIT_KEY),
    .hold      (state_q == ST_DEBOUNCE),
    .key_start (key_start),
    .key_valid (key_valid),
    .key_lost  (key_lost),
    .key_digit (key_digit)
  );

  assign waiting = (state_q == ST_WAIT_REL) || (state_q == ST_WAIT_KEY) ||
                   (state_q == ST_DEBOUNCE);

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    pos_d     = pos_q;
    dirty_d   = dirty_q;
    to_cnt_d  = to_cnt_q;
    timed_out = 1'b0;
    reject    = 1'b0;
    lim       = digit_limit(pos_q, buf_q[H_TEN_LSB +: 4]);
    lsb       = field_lsb(pos_q);

    // Inactivity timer: down-counter, only runs while waiting on the keypad.
    if (waiting) begin
      if (to_cnt_q == '0) timed_out = 1'b1;
      else                to_cnt_d  = to_cnt_q - 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (set_en) begin
          buf_d    = cur_time;
          pos_d    = 3'd0;
          dirty_d  = 1'b0;
          to_cnt_d = TW'(TIMEOUT - 1);
          state_d  = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: if (keypad == KEY_NONE) state_d = ST_WAIT_KEY;
      ST_WAIT_KEY: if (key_start) state_d = ST_DEBOUNCE;
      ST_DEBOUNCE: begin
        if (key_valid)     state_d = ST_APPLY;
        else if (key_lost) state_d = ST_WAIT_KEY;
      end
      ST_APPLY: begin
        if (key_digit <= lim) begin
          buf_d[lsb +: 4] = key_digit;
          // Hours 2x: clamp a stale hour-units digit so the buffer stays legal.
          if ((pos_q == 3'd0) && (key_digit == 4'd2) &&
              (buf_q[H_ONE_LSB +: 4] > LIM_H_ONE_20))
            buf_d[H_ONE_LSB +: 4] = LIM_H_ONE_20;
          dirty_d  = 1'b1;
          to_cnt_d = TW'(TIMEOUT - 1);
          if (pos_q == POS_LAST) begin
            state_d = ST_COMMIT;
          end else begin
            pos_d   = pos_q + 3'd1;
            state_d = ST_WAIT_REL;
          end
        end else begin
          reject  = 1'b1;
          state_d = ST_WAIT_REL;
        end
        // Switch dropped in the same cycle: the digit above still counts.
        if (!set_en) state_d = dirty_d ? ST_COMMIT : ST_IDLE;
      end
      ST_COMMIT: begin
        dirty_d = 1'b0;
        pos_d   = 3'd0;
        state_d = set_en ? ST_WAIT_REL : ST_IDLE;
      end
      ST_LOCKOUT: if (!set_en) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (waiting) begin
      if (!set_en) begin
        state_d = dirty_q ? ST_COMMIT : ST_IDLE;
      end else if (timed_out) begin
        state_d = ST_LOCKOUT;
        dirty_d = 1'b0;
      end
    end
  end

  // Free-running blink phase.
  always_comb begin
    blink_cnt_d = blink_cnt_q - 1'b1;
    phase_d     = phase_q;
    if (blink_cnt_q == '0) begin
      blink_cnt_d = BW'(BLINK_HALF - 1);
      phase_d     = ~phase_q;
    end
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe.
  always_comb begin
    edit_view    = (state_d != ST_IDLE) && (state_d != ST_LOCKOUT);
    load_stb_d   = (state_d == ST_COMMIT);
    load_time_d  = load_stb_d ? buf_d : load_time_q;
    err_d        = reject;
    busy_d       = (state_d != ST_IDLE);
    edit_pos_d   = edit_view ? pos_d : EDIT_IDLE;
    edit_time_d  = edit_view ? buf_d : cur_time;
    blink_mask_d = edit_view ? ({5'd0, phase_d} << (POS_LAST - pos_d)) : 6'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      buf_q        <= '0;
      pos_q        <= '0;
      dirty_q      <= 1'b0;
      to_cnt_q     <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      load_time_q  <= '0;
      load_stb_q   <= 1'b0;
      edit_time_q  <= '0;
      edit_pos_q   <= EDIT_IDLE;
      blink_mask_q <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      pos_q        <= pos_d;
      dirty_q      <= dirty_d;
      to_cnt_q     <= to_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      load_time_q  <= load_time_d;
      load_stb_q   <= load_stb_d;
      edit_time_q  <= edit_time_d;
      edit_pos_q   <= edit_pos_d;
      blink_mask_q <= blink_mask_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign load_time  = load_time_q;
  assign load_stb   = load_stb_q;
  assign edit_time  = edit_time_q;
  assign edit_pos   = edit_pos_q;
  assign blink_mask = blink_mask_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Keypad time-entry controller that sequences loading of the six BCD watch counters. It sits between the DIP switch and keypad inputs and the watch counter bank. It debounces key presses, steps an edit cursor across HH:MM:SS and rejects out-of-range digits. It then issues a single-cycle load strobe carrying a validated time, and it drives a staged-time and blink mask so the display scanner can show the edit in progress.

## Interface
- DEBOUNCE, 20, cycles a single-key code must be stable before acceptance
- TIMEOUT, 10000, cycles without an accepted key before the edit is abandoned
- BLINK_HALF, 250, cycles per blink half-period
- clk  in  1  system clock (1 kHz)
- rst  in  1  asynchronous, active-low reset
- set_en  in  1  DIP switch; 1 = edit mode requested
- keypad  in  10  active-low one-hot keys; bit k low = digit k; 10'h3FF = none
- cur_time  in  24  live watch time, BCD digits [23:20] h_ten … [3:0] s_one
- load_time  out  24  time to load into the watch counters; valid when load_stb = 1
- load_stb  out  1  one-cycle load pulse
- edit_time  out  24  staged buffer, for display while busy = 1
- edit_pos  out  3  cursor position 0–5 (h_ten…s_one); 7 = idle
- blink_mask  out  6  bit 5 = h_ten … bit 0 = s_one; 1 = blank the digit this cycle
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse on a rejected digit

## Operation
- States: IDLE, WAIT_REL, WAIT_KEY, DEBOUNCE, APPLY, COMMIT, LOCKOUT.
- IDLE, set_en = 1:
  - buffer ← cur_time, pos ← 0, dirty ← 0, go to WAIT_REL.
  - A key held at entry is therefore never taken.
- WAIT_REL: keypad = 3FF → WAIT_KEY.
- WAIT_KEY, keypad carries exactly one low bit:
  - latch the code, clear the debounce counter, go to DEBOUNCE.
  - Multi-key or other non-one-hot codes are ignored.
- DEBOUNCE:
  - Code unchanged for DEBOUNCE cycles → APPLY.
  - Any change → WAIT_KEY.
- APPLY, digit limits per position:
  - pos0 ≤ 2.
  - pos1 ≤ 9, or ≤ 3 when buffer h_ten = 2.
  - pos2 ≤ 5; pos3 ≤ 9; pos4 ≤ 5; pos5 ≤ 9.
- APPLY, digit accepted:
  - Write the digit, set dirty = 1, clear the timeout counter.
  - If pos0 is written with 2 and h_one > 3, force h_one to 3.
  - pos < 5 → pos + 1, WAIT_REL.
  - pos = 5 → COMMIT.
- APPLY, digit rejected: err pulse, pos unchanged, go to WAIT_REL.
- COMMIT: load_time ← buffer, load_stb = 1, dirty ← 0, pos ← 0 (wrap), go to WAIT_REL.
- set_en falls in any state except IDLE and LOCKOUT:
  - Enter COMMIT if dirty = 1, then go to IDLE instead of WAIT_REL.
  - Otherwise go straight to IDLE.
  - A partial edit is committed, with untouched digits keeping their cur_time snapshot.
- Timeout counter:
  - Runs in WAIT_REL, WAIT_KEY and DEBOUNCE.
  - On reaching TIMEOUT: discard the buffer, no load, go to LOCKOUT.
- LOCKOUT: stay until set_en = 0, then go to IDLE; the switch must be re-raised to edit again.
- Blink:
  - A free-running phase toggles every BLINK_HALF cycles.
  - blink_mask[5 − pos] = phase while in edit states; 0 in IDLE and LOCKOUT.
- edit_pos = 7 and edit_time = cur_time in IDLE and LOCKOUT.

## Timing
- Reset values:
  - State IDLE, load_time = 0, load_stb = 0, err = 0, busy = 0.
  - edit_pos = 7, blink_mask = 0, buffer = 0, all counters = 0.
- Press to buffer update: debounce qualifies on cycle N + DEBOUNCE, the write happens in APPLY, visible at N + DEBOUNCE + 2.
- Sixth accepted digit: load_stb is asserted the cycle after APPLY. The watch samples load_time only when load_stb = 1.
- All outputs are registered; err and load_stb never exceed one cycle.
- set_en fall and an APPLY in the same cycle: the APPLY completes first; its digit is included in the commit.
- Reset mid-edit: immediate return to IDLE; no load_stb is emitted.

## Structure
- Shared package time_set_pkg holds:
  - State encoding.
  - KEY_NONE = 10'h3FF and EDIT_IDLE = 3'd7.
  - Per-position digit limits.
  - BCD field offsets for the 24-bit time word.
- One sub-module, key_debounce, handles:
  - keypad → one-hot check.
  - Stable counter.
  - Outputs key_valid (one cycle) and key_digit [3:0].

## Test plan
- Reset asserted, then released → edit_pos = 7, load_stb = 0, busy = 0, blink_mask = 0.
- set_en = 1 with cur_time = 12:34:56, then keys 2,1,0,5,3,9, each held 30 cycles with releases between → one load_stb with load_time = 21:05:39, edit_pos returns to 0.
- At pos0 press 3 → err pulse, pos stays 0. Then press 2 with buffer h_one = 7 → h_one forced to 3, pos = 1. Then press 4 → err.
- A 10-cycle key glitch, and keypad = 3FC (two keys), both produce no buffer change.
- Enter 1,5 then drop set_en, with snapshot 08:20:10 → load_time = 15:20:10, one load_stb, then IDLE.
- No key for TIMEOUT cycles → LOCKOUT, no load_stb. Keys are ignored until set_en toggles low→high.
